// File: rtl/infer_mul_arbiter.sv
// infer_mul_arbiter: round-robin front end that shares one pipelined 21s x 15u
// multiplier between NUM_REQ requesters and returns id-tagged products in order.
// Optional feature: define INFER_MUL_ARB_STATS_EN to add the issue/stall counters
// stat_issue_cnt and stat_stall_cnt.
module infer_mul_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned MUL_LATENCY = 3,
  localparam int unsigned A_W        = 21,
  localparam int unsigned B_W        = 15,
  localparam int unsigned P_W        = 36,
  localparam int unsigned STAT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   mul_ce,
  output logic [A_W-1:0]         mul_din0,
  output logic [B_W-1:0]         mul_din1,
  input  logic [P_W-1:0]         mul_dout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [P_W-1:0]         rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   flush,
  output logic                   flush_done
`ifdef INFER_MUL_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]      stat_issue_cnt,
  output logic [STAT_W-1:0]      stat_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_n;
  logic [ID_W-1:0]        rr_ptr_q;
  logic [MUL_LATENCY-1:0] tag_vld_q;
  logic [ID_W-1:0]        tag_id_q [MUL_LATENCY];
  logic [A_W-1:0]         din0_q;
  logic [B_W-1:0]         din1_q;

  logic                   grant_any_c;
  logic [ID_W-1:0]        grant_idx_c;
  logic [ID_W-1:0]        cand_c;
  logic                   issue_c;
  logic                   pipe_empty_c;
  logic [A_W-1:0]         sel_a_c;
  logic [B_W-1:0]         sel_b_c;
  logic [ID_W-1:0]        ptr_next_c;

  // Results leave from the last tag stage; product passes straight through.
  assign rsp_valid    = tag_vld_q[MUL_LATENCY-1];
  assign rsp_id       = tag_id_q[MUL_LATENCY-1];
  assign rsp_data     = mul_dout;
  assign pipe_empty_c = ~|tag_vld_q;

  // Pipeline moves unless a presented result is being held off; frozen in reset.
  assign mul_ce  = reset_n & ~(rsp_valid & ~rsp_ready);
  assign issue_c = grant_any_c & mul_ce & ~flush & (state_q == ST_RUN);

  // Round-robin search: first valid requester at or after the pointer, with wrap.
  always_comb begin
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    cand_c      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_c = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_any_c && req_valid[cand_c]) begin
        grant_any_c = 1'b1;
        grant_idx_c = cand_c;
      end
    end
  end

  // Operand mux, one-hot accept and pointer successor for the granted requester.
  always_comb begin
    sel_a_c    = req_a[32'(grant_idx_c)*A_W +: A_W];
    sel_b_c    = req_b[32'(grant_idx_c)*B_W +: B_W];
    ptr_next_c = ID_W'((32'(grant_idx_c) + 32'd1) % NUM_REQ);
    req_ready  = '0;
    if (issue_c) begin
      req_ready[grant_idx_c] = 1'b1;
    end
    mul_din0 = issue_c ? sel_a_c : din0_q;
    mul_din1 = issue_c ? sel_b_c : din1_q;
  end

  // Remember the last issued operands and advance the fairness pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din0_q   <= '0;
      din1_q   <= '0;
      rr_ptr_q <= '0;
    end else if (issue_c) begin
      din0_q   <= sel_a_c;
      din1_q   <= sel_b_c;
      rr_ptr_q <= ptr_next_c;
    end
  end

  // Tag pipeline shadows the multiplier, advancing only on ce edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld_q <= '0;
      for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
        tag_id_q[i] <= '0;
      end
    end else if (mul_ce) begin
      tag_vld_q[0] <= issue_c;
      if (issue_c) begin
        tag_id_q[0] <= grant_idx_c;
      end
      for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  // Flush control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      flush_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      flush_done <= (state_n == ST_DONE);
    end
  end

  // Flush control next state: drain until empty, park until flush drops.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (flush) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!flush)            state_n = ST_RUN;
        else if (pipe_empty_c) state_n = ST_DONE;
      end
      ST_DONE: begin
        if (!flush) state_n = ST_RUN;
      end
      default: state_n = ST_RUN;
    endcase
  end

`ifdef INFER_MUL_ARB_STATS_EN
  // Saturating issue and stall counters, cleared while parked in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_issue_cnt <= '0;
      stat_stall_cnt <= '0;
    end else if (flush_done) begin
      stat_issue_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (issue_c && (stat_issue_cnt != {STAT_W{1'b1}})) begin
        stat_issue_cnt <= stat_issue_cnt + STAT_W'(1);
      end
      if (!mul_ce && (stat_stall_cnt != {STAT_W{1'b1}})) begin
        stat_stall_cnt <= stat_stall_cnt + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_infer_mul_arbiter.sv
// Bench for infer_mul_arbiter: behavioural queue model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_infer_mul_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 3;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_DONE  = 2;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*21-1:0] req_a;
  logic [NREQ*15-1:0] req_b;
  logic              mul_ce;
  logic [20:0]       mul_din0;
  logic [14:0]       mul_din1;
  logic [35:0]       mul_dout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [35:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              flush;
  logic              flush_done;
`ifdef INFER_MUL_ARB_STATS_EN
  logic [15:0]       stat_issue_cnt;
  logic [15:0]       stat_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  infer_mul_arbiter #(.NUM_REQ(NREQ), .ID_W(IDW), .MUL_LATENCY(LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .mul_ce     (mul_ce),
    .mul_din0   (mul_din0),
    .mul_din1   (mul_din1),
    .mul_dout   (mul_dout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .flush      (flush),
    .flush_done (flush_done)
`ifdef INFER_MUL_ARB_STATS_EN
    ,
    .stat_issue_cnt (stat_issue_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed 21-bit times zero-extended 15-bit, truncated to 36 bits.
  function automatic logic [35:0] mul_ref(input logic [20:0] a, input logic [14:0] b);
    logic signed [35:0] sa;
    logic signed [35:0] sb;
    sa = 36'($signed(a));
    sb = $signed({21'd0, b});
    return sa * sb;
  endfunction

  // Stand-in for the multiplier instance: LAT ce-enabled stages.
  logic [35:0] ms0, ms1, ms2;
  always @(posedge clk) begin
    if (mul_ce) begin
      ms0 <= mul_ref(mul_din0, mul_din1);
      ms1 <= ms0;
      ms2 <= ms1;
    end
  end
  assign mul_dout = ms2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          id;
    logic [35:0] prod;
    int          age;
  } op_t;

  op_t q[$];
  int  m_ptr;
  int  m_mode;
  bit  exp_vld;
  bit  exp_ce;
  int  exp_g;
  logic [NREQ-1:0] exp_rdy;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_mul_ce", 64'(mul_ce), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_flush_done", 64'(flush_done), 64'd0);
      chk("rst_din0", 64'(mul_din0), 64'd0);
      chk("rst_din1", 64'(mul_din1), 64'd0);
      q.delete();
      m_ptr  = 0;
      m_mode = M_RUN;
    end else begin
      exp_vld = (q.size() > 0) && (q[0].age >= LAT);
      exp_ce  = !(exp_vld && !rsp_ready);
      exp_g   = -1;
      if (m_mode == M_RUN && !flush && exp_ce) begin
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (exp_g < 0 && req_valid[c]) exp_g = c;
        end
      end
      exp_rdy = '0;
      if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;

      chk("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
      chk("mul_ce", 64'(mul_ce), 64'(exp_ce));
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("flush_done", 64'(flush_done), 64'(m_mode == M_DONE));
      if (exp_vld) begin
        chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
        chk("rsp_data", 64'(rsp_data), 64'(q[0].prod));
      end
      if (exp_g >= 0) begin
        chk("mul_din0", 64'(mul_din0), 64'(req_a[exp_g*21 +: 21]));
        chk("mul_din1", 64'(mul_din1), 64'(req_b[exp_g*15 +: 15]));
      end

      // Mode update uses the pre-edge occupancy.
      case (m_mode)
        M_RUN:   if (flush) m_mode = M_DRAIN;
        M_DRAIN: if (!flush) m_mode = M_RUN; else if (q.size() == 0) m_mode = M_DONE;
        default: if (!flush) m_mode = M_RUN;
      endcase

      if (exp_ce) begin
        if (exp_vld) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (exp_g >= 0) begin
          op_t n;
          n.id   = exp_g;
          n.prod = mul_ref(req_a[exp_g*21 +: 21], req_b[exp_g*15 +: 15]);
          n.age  = 1;
          q.push_back(n);
          m_ptr = (exp_g + 1) % NREQ;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [20:0] a, input logic [14:0] b);
    req_a[i*21 +: 21] = a;
    req_b[i*15 +: 15] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) set_op(i, 21'($urandom), 15'($urandom));
  endtask

  task automatic wait_rsp(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      else tick();
    end
    if (!seen) chk(name, 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      tick();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [63:0] e_neg;
    logic [63:0] e_pos;
    bit          hit;
    e_neg = -64'sd34358689792;
    e_pos = 64'sd34358657025;

    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    flush     = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    // Single op from requester 2: one-cycle accept, result three cycles later.
    req_valid = 4'b0100;
    set_op(2, -21'sd3, 15'd5);
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'(4'b0100));
    tick();
    req_valid = '0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("single_latency", 64'(rsp_valid), 64'(c == 3));
      if (c == 3) begin
        chk("single_id", 64'(rsp_id), 64'd2);
        chk("single_data", 64'(rsp_data), 64'h0_0000_000F_FFFF_FFF1 & 64'hF_FFFF_FFFF);
      end
      tick();
    end

    // Operand extremes, back to back from requester 0.
    req_valid = 4'b0001;
    set_op(0, 21'h100000, 15'h7FFF);
    @(negedge clk);
    tick();
    set_op(0, 21'h0FFFFF, 15'h7FFF);
    @(negedge clk);
    tick();
    req_valid = '0;
    wait_rsp("ext_wait");
    chk("ext_neg", {{28{rsp_data[35]}}, rsp_data}, e_neg);
    tick();
    @(negedge clk);
    chk("ext_pos_valid", 64'(rsp_valid), 64'd1);
    chk("ext_pos", {{28{rsp_data[35]}}, rsp_data}, e_pos);
    tick();
    idle(4);

    // Fairness from a fresh pointer: strict rotation, gap-free responses.
    do_reset();
    req_valid = 4'hF;
    rand_ops();
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k < 8) chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      if (k >= 3) begin
        chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rr_rsp_id", 64'(rsp_id), 64'((k - 3) % 4));
      end
      tick();
      rand_ops();
      if (k == 7) req_valid = '0;
    end
    idle(3);

    // Backpressure on a requester-1 stream.
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      tick();
      set_op(1, 21'($urandom), 15'($urandom));
      if (rsp_valid) hit = 1'b1;
    end
    if (!hit) chk("bp_wait", 64'd0, 64'd1);
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_ce_low", 64'(mul_ce), 64'd0);
      chk("bp_ready_low", 64'(req_ready), 64'd0);
      tick();
      set_op(1, 21'($urandom), 15'($urandom));
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tick();
      set_op(1, 21'($urandom), 15'($urandom));
    end
    req_valid = '0;
    idle(8);

    // Flush: three issues, then drain with requests still pending.
    req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tick();
      rand_ops();
    end
    flush = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("flush_no_grant", 64'(req_ready), 64'd0);
      chk("flush_done_time", 64'(flush_done), 64'(c >= 4));
      tick();
    end
    flush = 1'b0;
    @(negedge clk);
    chk("flush_hold_done", 64'(flush_done), 64'd1);
    chk("flush_hold_nogrant", 64'(req_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("flush_exit", 64'(flush_done), 64'd0);
    chk("flush_resume", 64'(req_ready != '0), 64'd1);
    tick();
    req_valid = '0;
    idle(6);

    // Reset with two results in flight.
    req_valid = 4'b1000;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    req_valid = '0;
    reset_n   = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_ce", 64'(mul_ce), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_din0", 64'(mul_din0), 64'd0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", 64'(rsp_valid), 64'd0);
      tick();
    end

    // Randomized traffic with backpressure and occasional flush.
    for (int c = 0; c < 800; c++) begin
      req_valid = NREQ'($urandom);
      rand_ops();
      rsp_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 3) flush = ~flush;
      @(negedge clk);
      tick();
    end
    flush     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    idle(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
